// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, widths and the
// instruction-cycle state encodings used by instr_ctrl.
package cpu_pkg;

  localparam int OP_W    = 3;
  localparam int STATE_W = 4;

  localparam logic [OP_W-1:0] OP_HLT = 3'd0;
  localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_LDA = 3'd5;
  localparam logic [OP_W-1:0] OP_STO = 3'd6;
  localparam logic [OP_W-1:0] OP_JMP = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH_OP = 4'd0,
    ST_INC1     = 4'd1,
    ST_FETCH_AD = 4'd2,
    ST_INC2     = 4'd3,
    ST_DECODE   = 4'd4,
    ST_EXEC1    = 4'd5,
    ST_EXEC2    = 4'd6,
    ST_EXEC3    = 4'd7,
    ST_HALTED   = 4'd8,
    ST_WAIT     = 4'd9
  } state_t;

endpackage

// File: rtl/instr_ctrl_dec.sv
// Combinational strobe decode for the instruction cycle, driven only by
// registered state, the fetch-active flag, latched opcode and latched zero.
module instr_ctrl_dec
  import cpu_pkg::*;
(
  input  state_t          state,
  input  logic            active,
  input  logic [OP_W-1:0] op,
  input  logic            zero_q,
  output logic            load_ir,
  output logic            load_ar,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            rd,
  output logic            wr,
  output logic            load_acc,
  output logic            datactl_ena,
  output logic            halt
);

  logic alu_op;
  logic skip;

  assign alu_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  assign skip   = (op == OP_SKZ) && zero_q;

  always_comb begin
    load_ir     = 1'b0;
    load_ar     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    if (state == ST_HALTED) begin
      halt = 1'b1;
    end else if (active) begin
      case (state)
        ST_FETCH_OP: begin
          rd      = 1'b1;
          load_ir = 1'b1;
        end
        ST_INC1:     inc_pc = 1'b1;
        ST_FETCH_AD: begin
          rd      = 1'b1;
          load_ar = 1'b1;
        end
        ST_INC2:     inc_pc = 1'b1;
        ST_DECODE:   halt = (op == OP_HLT);
        ST_EXEC1: begin
          rd          = alu_op;
          datactl_ena = (op == OP_STO);
          load_pc     = (op == OP_JMP);
          inc_pc      = skip;
        end
        // Second half of SKZ gives the +2 needed to skip a two-byte instruction.
        ST_EXEC2: begin
          rd          = alu_op;
          load_acc    = alu_op;
          wr          = (op == OP_STO);
          datactl_ena = (op == OP_STO);
          load_pc     = (op == OP_JMP);
          inc_pc      = skip;
        end
        ST_EXEC3:    datactl_ena = (op == OP_STO);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_ctrl.sv
// Instruction sequencing controller: 8-phase cycle per instruction.
// Optional single-step WAIT state after EXEC3 under macro INSTR_CTRL_STEP_EN.
//
// state       | meaning
// FETCH_OP    | read opcode byte into IR
// INC1        | advance PC, latch opcode
// FETCH_AD    | read operand byte into AR
// INC2        | advance PC
// DECODE      | latch zero flag, HLT asserts halt
// EXEC1..3    | opcode-specific execution phases
// HALTED      | halt held until reset
// WAIT        | (step build) idle until step pulse
module instr_ctrl
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
`ifdef INSTR_CTRL_STEP_EN
  input  logic            step,
`endif
  output logic            load_ir,
  output logic            load_ar,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            rd,
  output logic            wr,
  output logic            load_acc,
  output logic            datactl_ena,
  output logic            halt
);

  state_t          state, state_nxt;
  logic            active_q;
  logic [OP_W-1:0] op_q;
  logic            zero_q;
  logic            run;

  // active_q separates an idle FETCH_OP (after reset or ena low) from a real fetch.
  assign run = ena && active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH_OP;
      active_q <= 1'b0;
      op_q     <= '0;
      zero_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      active_q <= ena;
      if (run && state == ST_INC1)   op_q   <= opcode;
      if (run && state == ST_DECODE) zero_q <= zero;
    end
  end

  always_comb begin
    state_nxt = ST_FETCH_OP;
    if (state == ST_HALTED) begin
      state_nxt = ST_HALTED;
    end else if (run) begin
      case (state)
        ST_FETCH_OP: state_nxt = ST_INC1;
        ST_INC1:     state_nxt = ST_FETCH_AD;
        ST_FETCH_AD: state_nxt = ST_INC2;
        ST_INC2:     state_nxt = ST_DECODE;
        ST_DECODE:   state_nxt = (op_q == OP_HLT) ? ST_HALTED : ST_EXEC1;
        ST_EXEC1:    state_nxt = ST_EXEC2;
        ST_EXEC2:    state_nxt = ST_EXEC3;
`ifdef INSTR_CTRL_STEP_EN
        ST_EXEC3:    state_nxt = ST_WAIT;
        ST_WAIT:     state_nxt = step ? ST_FETCH_OP : ST_WAIT;
`else
        ST_EXEC3:    state_nxt = ST_FETCH_OP;
`endif
        default:     state_nxt = ST_FETCH_OP;
      endcase
    end
  end

  instr_ctrl_dec u_dec (
    .state       (state),
    .active      (active_q),
    .op          (op_q),
    .zero_q      (zero_q),
    .load_ir     (load_ir),
    .load_ar     (load_ar),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .rd          (rd),
    .wr          (wr),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed table-driven bench for instr_ctrl; step-mode sequence when
// INSTR_CTRL_STEP_EN is defined.
module tb_instr_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst, ena, zero;
  logic [OP_W-1:0] opcode;
`ifdef INSTR_CTRL_STEP_EN
  logic step;
`endif
  logic load_ir, load_ar, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, halt;
  logic [8:0] obs;

  instr_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
`ifdef INSTR_CTRL_STEP_EN
    .step        (step),
`endif
    .load_ir     (load_ir),
    .load_ar     (load_ar),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .rd          (rd),
    .wr          (wr),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  assign obs = {load_ir, load_ar, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, halt};

  localparam logic [8:0] X_IR  = 9'h100;
  localparam logic [8:0] X_AR  = 9'h080;
  localparam logic [8:0] X_INC = 9'h040;
  localparam logic [8:0] X_PC  = 9'h020;
  localparam logic [8:0] X_RD  = 9'h010;
  localparam logic [8:0] X_WR  = 9'h008;
  localparam logic [8:0] X_ACC = 9'h004;
  localparam logic [8:0] X_DB  = 9'h002;
  localparam logic [8:0] X_HLT = 9'h001;
  localparam logic [8:0] X_0   = 9'h000;
  localparam logic [8:0] X_FET = X_IR | X_RD;
  localparam logic [8:0] X_OPR = X_AR | X_RD;

  typedef struct {
    logic       rst;
    logic       ena;
    logic [2:0] op;
    logic       zero;
    logic [8:0] exp;
    string      nm;
  } vec_t;

  vec_t vecs[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic add(input logic r, input logic e, input logic [2:0] o,
                     input logic z, input logic [8:0] x, input string nm);
    vec_t v;
    v.rst = r; v.ena = e; v.op = o; v.zero = z; v.exp = x; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [8:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: strobes got %b expected %b", nm, obs, exp);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; opcode = '0; zero = 1'b0;
`ifdef INSTR_CTRL_STEP_EN
    step = 1'b0;
    tick(); check("step_reset", X_0);
    rst = 1'b0; ena = 1'b1; opcode = OP_LDA;
    tick(); check("step_fetch", X_FET);
    for (int i = 1; i < 8; i++) tick();
    check("step_s7", X_0);
    tick(); check("step_wait0", X_0);
    tick(); check("step_wait1", X_0);
    tick(); check("step_wait2", X_0);
    step = 1'b1;
    tick(); check("step_go", X_FET);
    step = 1'b0;
    tick(); check("step_s1", X_INC);
    for (int i = 2; i < 8; i++) tick();
    tick(); check("step_wait_b", X_0);
    step = 1'b1; ena = 1'b0;
    tick(); check("step_ena_wins", X_0);
    step = 1'b0; ena = 1'b1;
    tick(); check("step_refetch", X_FET);
    rst = 1'b1;
    tick(); check("step_rst", X_0);
`else
    add(1, 0, OP_LDA, 0, X_0,           "rst0");
    add(1, 1, OP_LDA, 0, X_0,           "rst1");
    add(0, 1, OP_LDA, 0, X_FET,         "lda_s0");
    add(0, 1, OP_LDA, 0, X_INC,         "lda_s1");
    add(0, 1, OP_LDA, 0, X_OPR,         "lda_s2");
    add(0, 1, OP_LDA, 0, X_INC,         "lda_s3");
    add(0, 1, OP_LDA, 0, X_0,           "lda_s4");
    add(0, 1, OP_LDA, 0, X_RD,          "lda_s5");
    add(0, 1, OP_LDA, 0, X_RD | X_ACC,  "lda_s6");
    add(0, 1, OP_LDA, 0, X_0,           "lda_s7");
    add(0, 1, OP_LDA, 0, X_FET,         "lda_next");
    add(0, 1, OP_STO, 0, X_INC,         "sto_s1");
    add(0, 1, OP_STO, 0, X_OPR,         "sto_s2");
    add(0, 1, OP_STO, 0, X_INC,         "sto_s3");
    add(0, 1, OP_STO, 0, X_0,           "sto_s4");
    add(0, 1, OP_STO, 0, X_DB,          "sto_s5");
    add(0, 1, OP_STO, 0, X_WR | X_DB,   "sto_s6");
    add(0, 1, OP_STO, 0, X_DB,          "sto_s7");
    add(0, 1, OP_STO, 0, X_FET,         "sto_next");
    add(0, 1, OP_SKZ, 1, X_INC,         "skz1_s1");
    add(0, 1, OP_SKZ, 1, X_OPR,         "skz1_s2");
    add(0, 1, OP_SKZ, 1, X_INC,         "skz1_s3");
    add(0, 1, OP_SKZ, 1, X_0,           "skz1_s4");
    add(0, 1, OP_SKZ, 1, X_INC,         "skz1_s5");
    add(0, 1, OP_SKZ, 0, X_INC,         "skz1_s6");
    add(0, 1, OP_SKZ, 0, X_0,           "skz1_s7");
    add(0, 1, OP_SKZ, 0, X_FET,         "skz1_next");
    add(0, 1, OP_SKZ, 0, X_INC,         "skz0_s1");
    add(0, 1, OP_SKZ, 0, X_OPR,         "skz0_s2");
    add(0, 1, OP_SKZ, 0, X_INC,         "skz0_s3");
    add(0, 1, OP_SKZ, 0, X_0,           "skz0_s4");
    add(0, 1, OP_SKZ, 0, X_0,           "skz0_s5");
    add(0, 1, OP_SKZ, 1, X_0,           "skz0_s6");
    add(0, 1, OP_SKZ, 1, X_0,           "skz0_s7");
    add(0, 1, OP_JMP, 0, X_FET,         "skz0_next");
    add(0, 1, OP_JMP, 0, X_INC,         "jmp_s1");
    add(0, 1, OP_JMP, 0, X_OPR,         "jmp_s2");
    add(0, 1, OP_JMP, 0, X_INC,         "jmp_s3");
    add(0, 1, OP_JMP, 0, X_0,           "jmp_s4");
    add(0, 1, OP_JMP, 0, X_PC,          "jmp_s5");
    add(0, 0, OP_JMP, 0, X_0,           "jmp_ena_drop");
    add(0, 1, OP_JMP, 0, X_FET,         "jmp_restart");
    add(0, 1, OP_JMP, 0, X_INC,         "jmp2_s1");
    add(0, 1, OP_JMP, 0, X_OPR,         "jmp2_s2");
    add(0, 1, OP_JMP, 0, X_INC,         "jmp2_s3");
    add(0, 1, OP_JMP, 0, X_0,           "jmp2_s4");
    add(0, 1, OP_JMP, 0, X_PC,          "jmp2_s5");
    add(0, 1, OP_JMP, 0, X_PC,          "jmp2_s6");
    add(0, 1, OP_JMP, 0, X_0,           "jmp2_s7");
    add(0, 1, OP_JMP, 0, X_FET,         "jmp2_next");
    add(0, 1, OP_HLT, 0, X_INC,         "hlt_s1");
    add(0, 1, OP_HLT, 0, X_OPR,         "hlt_s2");
    add(0, 1, OP_HLT, 0, X_INC,         "hlt_s3");
    add(0, 1, OP_HLT, 0, X_HLT,         "hlt_s4");
    for (int i = 0; i < 20; i++)
      add(0, (i % 2 == 0), OP_HLT, 0, X_HLT, "hlt_hold");
    add(1, 1, OP_HLT, 0, X_0,           "hlt_rst");
    add(0, 1, OP_LDA, 0, X_FET,         "hlt_refetch");

    foreach (vecs[i]) begin
      rst = vecs[i].rst; ena = vecs[i].ena; opcode = vecs[i].op; zero = vecs[i].zero;
      tick();
      check(vecs[i].nm, vecs[i].exp);
    end

    // reset in the middle of an instruction
    rst = 1'b1; tick();
    rst = 1'b0; ena = 1'b1; opcode = OP_ADD;
    tick(); check("mid_fetch", X_FET);
    tick();
    tick(); check("mid_s2", X_OPR);
    rst = 1'b1;
    tick(); check("mid_rst", X_0);
    rst = 1'b0;
    tick(); check("mid_refetch", X_FET);

    // bounded wait for halt: expected in the 5th cycle after release
    rst = 1'b1; tick();
    rst = 1'b0; opcode = OP_HLT;
    begin
      int cyc;
      cyc = 0;
      while (!halt && cyc < 16) begin
        tick();
        cyc++;
      end
      n_total++;
      if (cyc == 5) n_pass++;
      else $display("FAIL hlt_latency: cycles got %0d expected 5", cyc);
    end
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
